spi_slave: RTL and testbench

- SPI slave endpoint for the spi_master link: consumes sclk/cs_n/mosi and drives miso.
- Oversamples the SPI pins in the system clock domain.
- Deserialises the MOSI word MSB-first and serialises a pre-loaded response word MSB-first on MISO.
- Sits at the peripheral side of the link; a user-side valid/ready handshake supplies TX words and delivers RX words.

---
 rtl/spi_slave.sv | 190 +++++++++++++++++++
 tb/tb_spi_slave.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI peripheral endpoint oversampled in the clk domain.
// Deserialises MOSI and serialises a pre-loaded response on MISO, both MSB-first.
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   sclk, cs_n, mosi     SPI pins from the master (asynchronous to clk)
//   miso, miso_oe        SPI slave-out data and its pad enable
//   tx_data/valid/ready  user-side TX word handshake (one-word holding buffer)
//   rx_data, rx_valid    received word and its one-cycle strobe
//   tx_underrun          frame started with no TX word buffered
//   frame_abort          cs_n rose before a full word was sampled
module spi_slave #(
   parameter int unsigned DATA_WIDTH = 6,
   parameter bit          CPOL       = 1'b0,
   parameter bit          CPHA       = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  tx_underrun,
   output logic                  frame_abort
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t state, state_nxt;

   // [0] metastable stage, [1] synchronised value, [2] history for edge detection
   logic [2:0] sclk_q;
   logic [2:0] cs_q;
   // mosi is only sampled, never edge-detected, so it needs no history stage
   logic [1:0] mosi_q;

   logic [DATA_WIDTH-1:0] tx_sr, tx_sr_nxt;
   logic [DATA_WIDTH-1:0] tx_buf;
   logic [DATA_WIDTH-2:0] rx_sr;
   logic [DATA_WIDTH-1:0] rx_sr_nxt;
   logic [CNT_W-1:0]      cnt;
   logic                  skip_first;

   logic sclk_lead, sclk_trail, cs_fall, cs_rise;
   logic sample_edge, shift_edge, cnt_last;
   logic load_c, sample_c, shift_c, done_c, abort_c, underrun_c;

   // Pin synchronisers, preset to the idle bus levels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q <= {3{CPOL}};
         cs_q   <= 3'b111;
         mosi_q <= 2'b00;
      end else begin
         sclk_q <= {sclk_q[1:0], sclk};
         cs_q   <= {cs_q[1:0], cs_n};
         mosi_q <= {mosi_q[0], mosi};
      end
   end

   // Edge strobes on (sync, history)
   always_comb begin
      sclk_lead   = (sclk_q[1] != CPOL) && (sclk_q[2] == CPOL);
      sclk_trail  = (sclk_q[1] == CPOL) && (sclk_q[2] != CPOL);
      cs_fall     = !cs_q[1] && cs_q[2];
      cs_rise     = cs_q[1] && !cs_q[2];
      sample_edge = CPHA ? sclk_trail : sclk_lead;
      shift_edge  = CPHA ? sclk_lead  : sclk_trail;
      cnt_last    = (cnt == CNT_W'(DATA_WIDTH - 1));
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cs_fall) state_nxt = ACTIVE;
         ACTIVE: begin
            if (cs_rise)                      state_nxt = IDLE;
            else if (sample_edge && cnt_last) state_nxt = HOLD;
         end
         HOLD:    if (cs_rise) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM control strobes
   always_comb begin
      load_c     = 1'b0;
      sample_c   = 1'b0;
      shift_c    = 1'b0;
      done_c     = 1'b0;
      abort_c    = 1'b0;
      underrun_c = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               load_c     = 1'b1;
               // a same-cycle handshake supplies the word directly
               underrun_c = tx_ready && !tx_valid;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               abort_c = 1'b1;
            end else begin
               sample_c = sample_edge;
               done_c   = sample_edge && cnt_last;
               // CPHA=1: MSB must survive the first leading edge
               shift_c  = shift_edge && !skip_first;
            end
         end
         default: ;
      endcase
   end

   // Shift register next values
   always_comb begin
      tx_sr_nxt = tx_sr;
      if (load_c) begin
         if (!tx_ready)     tx_sr_nxt = tx_buf;
         else if (tx_valid) tx_sr_nxt = tx_data;
         else               tx_sr_nxt = '0;
      end else if (shift_c) begin
         tx_sr_nxt = {tx_sr[DATA_WIDTH-2:0], 1'b0};
      end
      rx_sr_nxt = {rx_sr, mosi_q[1]};
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_sr       <= '0;
         tx_buf      <= '0;
         tx_ready    <= 1'b1;
         rx_sr       <= '0;
         cnt         <= '0;
         skip_first  <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_abort <= 1'b0;
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
      end else begin
         tx_sr <= tx_sr_nxt;
         if (load_c) begin
            tx_ready <= 1'b1;
         end else if (tx_valid && tx_ready) begin
            tx_buf   <= tx_data;
            tx_ready <= 1'b0;
         end

         if (load_c) begin
            cnt        <= '0;
            skip_first <= CPHA;
         end else begin
            if (sample_c) begin
               rx_sr <= rx_sr_nxt[DATA_WIDTH-2:0];
               cnt   <= cnt + CNT_W'(1);
            end
            if (state == ACTIVE && shift_edge) skip_first <= 1'b0;
         end

         if (done_c) rx_data <= rx_sr_nxt;
         rx_valid    <= done_c;
         tx_underrun <= underrun_c;
         frame_abort <= abort_c;
         miso_oe     <= (state_nxt != IDLE);
         miso        <= (state_nxt == ACTIVE) ? tx_sr_nxt[DATA_WIDTH-1] : 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 and a mode-3 instance driven by a behavioural
// SPI master, checked against a word-level model of the TX buffer and frames.
module tb_spi_slave;

   localparam int unsigned W = 6;
   localparam int          H = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic         sclk[2], cs_n[2], mosi[2], miso[2], miso_oe[2];
   logic         tx_valid[2], tx_ready[2], rx_valid[2], tx_underrun[2], frame_abort[2];
   logic [W-1:0] tx_data[2], rx_data[2];

   always #5 clk = ~clk;

   spi_slave #(.DATA_WIDTH(W), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]),
      .miso(miso[0]), .miso_oe(miso_oe[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
      .tx_ready(tx_ready[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
      .tx_underrun(tx_underrun[0]), .frame_abort(frame_abort[0]));

   spi_slave #(.DATA_WIDTH(W), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]),
      .miso(miso[1]), .miso_oe(miso_oe[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
      .tx_ready(tx_ready[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
      .tx_underrun(tx_underrun[1]), .frame_abort(frame_abort[1]));

   // pulse counters (cycles high)
   int rxv_cnt[2] = '{0, 0};
   int und_cnt[2] = '{0, 0};
   int ab_cnt[2]  = '{0, 0};

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rx_valid[k])    rxv_cnt[k] <= rxv_cnt[k] + 1;
         if (tx_underrun[k]) und_cnt[k] <= und_cnt[k] + 1;
         if (frame_abort[k]) ab_cnt[k]  <= ab_cnt[k] + 1;
      end
   end

   // reference model state
   bit           exp_full[2];
   logic [W-1:0] exp_buf[2];
   logic [W-1:0] exp_rx[2];
   int           exp_und[2];

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input int m, input string when);
      check($sformatf("%s m%0d miso", when, m),        32'(miso[m]), 32'd0);
      check($sformatf("%s m%0d miso_oe", when, m),     32'(miso_oe[m]), 32'd0);
      check($sformatf("%s m%0d tx_ready", when, m),    32'(tx_ready[m]), 32'd1);
      check($sformatf("%s m%0d rx_data", when, m),     32'(rx_data[m]), 32'd0);
      check($sformatf("%s m%0d rx_valid", when, m),    32'(rx_valid[m]), 32'd0);
      check($sformatf("%s m%0d tx_underrun", when, m), 32'(tx_underrun[m]), 32'd0);
      check($sformatf("%s m%0d frame_abort", when, m), 32'(frame_abort[m]), 32'd0);
   endtask

   // offer a word; ok=1 once accepted within max_wait cycles
   task automatic push_tx(input int m, input logic [W-1:0] d, input int max_wait, output bit ok);
      @(negedge clk);
      tx_data[m]  = d;
      tx_valid[m] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < max_wait && !ok; i++) begin
         if (tx_ready[m]) ok = 1'b1;
         @(negedge clk);
      end
      tx_valid[m] = 1'b0;
      if (ok) begin
         exp_full[m] = 1'b1;
         exp_buf[m]  = d;
      end
   endtask

   // behavioural master: m=0 is mode 0, m=1 is mode 3
   task automatic spi_frame(input int m, input logic [W-1:0] wout, input int nbits,
                            input bit end_cs, output logic [W-1:0] win);
      logic [W-1:0] r;
      r = '0;
      @(negedge clk);
      cs_n[m] = 1'b0;
      if (m == 0) mosi[m] = wout[W-1];
      repeat (H) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (m == 0) begin
            sclk[m] = 1'b1;
            r = {r[W-2:0], miso[m]};
            repeat (H) @(negedge clk);
            sclk[m] = 1'b0;
            if (i < int'(W) - 1) mosi[m] = wout[W-2-i];
            repeat (H) @(negedge clk);
         end else begin
            sclk[m] = 1'b0;
            mosi[m] = wout[W-1-i];
            repeat (H) @(negedge clk);
            sclk[m] = 1'b1;
            r = {r[W-2:0], miso[m]};
            repeat (H) @(negedge clk);
         end
      end
      if (end_cs) begin
         repeat (H) @(negedge clk);
         cs_n[m] = 1'b1;
         mosi[m] = 1'b0;
         repeat (2 * H) @(negedge clk);
      end
      win = r;
   endtask

   // frame with model prediction and checks
   task automatic do_frame(input int m, input logic [W-1:0] wout, input int nbits, input bit end_cs);
      logic [W-1:0] sent, got;
      int rxv0, ab0;
      sent = exp_full[m] ? exp_buf[m] : '0;
      if (!exp_full[m]) exp_und[m]++;
      exp_full[m] = 1'b0;
      rxv0 = rxv_cnt[m];
      ab0  = ab_cnt[m];
      spi_frame(m, wout, nbits, end_cs, got);
      if (end_cs) begin
         if (nbits == int'(W)) begin
            check($sformatf("m%0d master rx", m), 32'(got), 32'(sent));
            check($sformatf("m%0d rx_data", m), 32'(rx_data[m]), 32'(wout));
            check($sformatf("m%0d rx_valid pulses", m), 32'(rxv_cnt[m]), 32'(rxv0 + 1));
            check($sformatf("m%0d no abort", m), 32'(ab_cnt[m]), 32'(ab0));
            exp_rx[m] = wout;
         end else begin
            check($sformatf("m%0d abort pulse", m), 32'(ab_cnt[m]), 32'(ab0 + 1));
            check($sformatf("m%0d no rx_valid", m), 32'(rxv_cnt[m]), 32'(rxv0));
            check($sformatf("m%0d rx_data held", m), 32'(rx_data[m]), 32'(exp_rx[m]));
         end
         check($sformatf("m%0d underruns", m), 32'(und_cnt[m]), 32'(exp_und[m]));
         check($sformatf("m%0d tx_ready", m), 32'(tx_ready[m]), 32'(!exp_full[m]));
         check($sformatf("m%0d miso_oe idle", m), 32'(miso_oe[m]), 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok, okc;
      logic [W-1:0] got, w;
      int rxv0, und0, ab0;

      for (int m = 0; m < 2; m++) begin
         sclk[m] = (m == 1); cs_n[m] = 1'b1; mosi[m] = 1'b0;
         tx_valid[m] = 1'b0; tx_data[m] = '0;
         exp_full[m] = 1'b0; exp_buf[m] = '0; exp_rx[m] = '0; exp_und[m] = 0;
      end

      repeat (3) @(negedge clk);
      chk_reset(0, "in reset");
      chk_reset(1, "in reset");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk_reset(0, "idle");

      // nominal frames, both modes
      for (int m = 0; m < 2; m++) begin
         push_tx(m, 6'b110010, 10, ok);
         check($sformatf("m%0d push accepted", m), 32'(ok), 32'd1);
         check($sformatf("m%0d tx_ready after push", m), 32'(tx_ready[m]), 32'd0);
         do_frame(m, 6'b101101, W, 1'b1);
      end

      // underrun
      for (int m = 0; m < 2; m++) do_frame(m, 6'b000111, W, 1'b1);

      // abort after 3 bits, then a clean frame
      for (int m = 0; m < 2; m++) begin
         push_tx(m, W'($urandom), 10, ok);
         do_frame(m, W'($urandom), 3, 1'b1);
         push_tx(m, W'($urandom), 10, ok);
         do_frame(m, 6'b010101, W, 1'b1);
      end

      // tx handshake coincident with the synced cs_n fall
      rxv0 = rxv_cnt[0];
      und0 = und_cnt[0];
      w = W'($urandom);
      fork
         spi_frame(0, w, W, 1'b1, got);
         begin
            repeat (3) @(negedge clk);
            tx_data[0] = 6'b111000;
            tx_valid[0] = 1'b1;
            @(negedge clk);
            tx_valid[0] = 1'b0;
         end
      join
      check("sim master rx", 32'(got), 32'(6'b111000));
      check("sim no underrun", 32'(und_cnt[0]), 32'(und0));
      check("sim rx_data", 32'(rx_data[0]), 32'(w));
      check("sim rx_valid", 32'(rxv_cnt[0]), 32'(rxv0 + 1));
      check("sim tx_ready", 32'(tx_ready[0]), 32'd1);
      exp_rx[0] = w;

      // a second word held while the buffer is full waits for the next frame
      push_tx(0, 6'b011110, 10, ok);
      okc = 1'b0;
      fork
         push_tx(0, 6'b100110, 2000, okc);
         begin
            repeat (20) @(negedge clk);
            check("held tx_ready low", 32'(tx_ready[0]), 32'd0);
            do_frame(0, W'($urandom), W, 1'b1);
         end
      join
      check("held word accepted", 32'(okc), 32'd1);
      do_frame(0, W'($urandom), W, 1'b1);

      // randomized frames
      for (int k = 0; k < 6; k++) begin
         for (int m = 0; m < 2; m++) begin
            if ($urandom_range(0, 3) != 0) push_tx(m, W'($urandom), 10, ok);
            do_frame(m, W'($urandom), W, 1'b1);
         end
      end

      // reset mid-frame after 2 bits
      push_tx(0, W'($urandom), 10, ok);
      do_frame(0, W'($urandom), 2, 1'b0);
      rxv0 = rxv_cnt[0];
      ab0  = ab_cnt[0];
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset(0, "mid-frame reset");
      chk_reset(1, "mid-frame reset");
      cs_n[0] = 1'b1;
      mosi[0] = 1'b0;
      for (int m = 0; m < 2; m++) begin
         exp_full[m] = 1'b0;
         exp_rx[m] = '0;
      end
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * H) @(negedge clk);
      check("reset no rx_valid", 32'(rxv_cnt[0]), 32'(rxv0));
      check("reset no abort", 32'(ab_cnt[0]), 32'(ab0));
      check("reset no underrun", 32'(und_cnt[0]), 32'(exp_und[0]));
      for (int m = 0; m < 2; m++) begin
         push_tx(m, W'($urandom), 10, ok);
         do_frame(m, 6'b100001, W, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
